// File: rtl/bicubic_window_feeder.sv
// bicubic_window_feeder
//   Requester side of the bicubic core handshake. Builds a sliding 4x4 source
//   window from 4-row pixel columns, issues it to the core as p1..p16, captures
//   the 16 interpolated pixels returned by the core and drains them as four
//   4-pixel output rows. Only one window is outstanding at the core at a time.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   col_valid/ready/data/last source column stream (row 0 in the low lane)
//   bf_req_valid, bcci_req_ready, p1..p16      window request to the core
//   bcci_rsp_valid, bf_rsp_ready, bcci_rsp_data1..16   core result
//   out_valid/ready/data/row/band_last         output row stream
//
// Optional feature: define BCCI_FEEDER_PERF_CNT_EN to add the win_cnt
// (request handshakes, wrapping) and stall_cnt (output stall cycles,
// saturating) 32-bit counter outputs.
module bicubic_window_feeder #(
  parameter int CHANNEL_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       col_valid,
  output logic                       col_ready,
  input  logic [4*CHANNEL_WIDTH-1:0] col_data,
  input  logic                       col_last,
  output logic                       bf_req_valid,
  input  logic                       bcci_req_ready,
  output logic [CHANNEL_WIDTH-1:0]   p1,  p2,  p3,  p4,
  output logic [CHANNEL_WIDTH-1:0]   p5,  p6,  p7,  p8,
  output logic [CHANNEL_WIDTH-1:0]   p9,  p10, p11, p12,
  output logic [CHANNEL_WIDTH-1:0]   p13, p14, p15, p16,
  input  logic                       bcci_rsp_valid,
  output logic                       bf_rsp_ready,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data1,  bcci_rsp_data2,  bcci_rsp_data3,  bcci_rsp_data4,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data5,  bcci_rsp_data6,  bcci_rsp_data7,  bcci_rsp_data8,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data9,  bcci_rsp_data10, bcci_rsp_data11, bcci_rsp_data12,
  input  logic [CHANNEL_WIDTH-1:0]   bcci_rsp_data13, bcci_rsp_data14, bcci_rsp_data15, bcci_rsp_data16,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [4*CHANNEL_WIDTH-1:0] out_data,
  output logic [1:0]                 out_row,
  output logic                       out_band_last
`ifdef BCCI_FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]                win_cnt,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int CW    = CHANNEL_WIDTH;
  localparam int COL_W = 4 * CHANNEL_WIDTH;

  typedef enum logic [1:0] {FILL, REQ, WAIT_RSP, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] win [4];          // win[0] is the oldest column
  logic [2:0]       cnt, cnt_nxt, cnt_inc;
  logic             win_last, win_last_nxt;
  logic             blk_last;
  logic             flush_pend;
  logic [1:0]       row_idx;
  logic [CW-1:0]    rsp_buf [16];
  logic [CW-1:0]    rsp_in  [16];
  logic [CW-1:0]    pix     [16];
  logic             col_hs, req_hs, rsp_hs, out_hs;

  // The last window of a band stays parked until its request goes out.
  assign flush_pend   = win_last;
  assign col_ready    = (cnt < 3'd4) && !flush_pend;
  assign bf_req_valid = (state == REQ);
  assign bf_rsp_ready = (state == REQ) || (state == WAIT_RSP);
  assign out_valid    = (state == DRAIN);
  assign out_row      = row_idx;
  assign out_band_last = blk_last && (row_idx == 2'd3) && out_valid;

  assign col_hs  = col_valid && col_ready;
  assign req_hs  = bf_req_valid && bcci_req_ready;
  assign rsp_hs  = bcci_rsp_valid && bf_rsp_ready;
  assign out_hs  = out_valid && out_ready;
  assign cnt_inc = cnt + 3'd1;

  always_comb begin
    cnt_nxt      = cnt;
    win_last_nxt = win_last;
    if (req_hs) begin
      // Last window of a band empties the window; otherwise slide by one.
      cnt_nxt      = win_last ? 3'd0 : 3'd3;
      win_last_nxt = 1'b0;
    end else if (col_hs) begin
      if (col_last && (cnt_inc != 3'd4)) begin
        cnt_nxt = 3'd0;               // band narrower than a window: drop it
      end else begin
        cnt_nxt = cnt_inc;
        if (col_last) win_last_nxt = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      // Look at the post-update count so the request follows the 4th column
      // by a single cycle.
      FILL:     if (cnt_nxt == 3'd4) state_nxt = REQ;
      REQ:      if (req_hs) state_nxt = rsp_hs ? DRAIN : WAIT_RSP;
      WAIT_RSP: if (rsp_hs) state_nxt = DRAIN;
      DRAIN:    if (out_hs && (row_idx == 2'd3)) state_nxt = (cnt == 3'd4) ? REQ : FILL;
      default:  state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      cnt      <= 3'd0;
      win_last <= 1'b0;
      blk_last <= 1'b0;
      row_idx  <= 2'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      win_last <= win_last_nxt;
      if (req_hs) blk_last <= win_last;
      if (rsp_hs)      row_idx <= 2'd0;
      else if (out_hs) row_idx <= row_idx + 2'd1;
    end
  end

  // Data registers carry no reset; the outputs below are gated by state.
  always_ff @(posedge clk) begin
    if (col_hs) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= win[3];
      win[3] <= col_data;
    end
    if (rsp_hs) begin
      for (int i = 0; i < 16; i++) rsp_buf[i] <= rsp_in[i];
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pix[{2'(r), 2'(c)}] = bf_req_valid ? win[c][r*CW +: CW] : '0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      for (int c = 0; c < 4; c++) out_data[c*CW +: CW] = rsp_buf[{row_idx, 2'(c)}];
    end
  end

  assign p1  = pix[0];  assign p2  = pix[1];  assign p3  = pix[2];  assign p4  = pix[3];
  assign p5  = pix[4];  assign p6  = pix[5];  assign p7  = pix[6];  assign p8  = pix[7];
  assign p9  = pix[8];  assign p10 = pix[9];  assign p11 = pix[10]; assign p12 = pix[11];
  assign p13 = pix[12]; assign p14 = pix[13]; assign p15 = pix[14]; assign p16 = pix[15];

  assign rsp_in[0]  = bcci_rsp_data1;  assign rsp_in[1]  = bcci_rsp_data2;
  assign rsp_in[2]  = bcci_rsp_data3;  assign rsp_in[3]  = bcci_rsp_data4;
  assign rsp_in[4]  = bcci_rsp_data5;  assign rsp_in[5]  = bcci_rsp_data6;
  assign rsp_in[6]  = bcci_rsp_data7;  assign rsp_in[7]  = bcci_rsp_data8;
  assign rsp_in[8]  = bcci_rsp_data9;  assign rsp_in[9]  = bcci_rsp_data10;
  assign rsp_in[10] = bcci_rsp_data11; assign rsp_in[11] = bcci_rsp_data12;
  assign rsp_in[12] = bcci_rsp_data13; assign rsp_in[13] = bcci_rsp_data14;
  assign rsp_in[14] = bcci_rsp_data15; assign rsp_in[15] = bcci_rsp_data16;

`ifdef BCCI_FEEDER_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (req_hs) win_cnt <= win_cnt + 32'd1;
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bicubic_window_feeder.sv
module tb_bicubic_window_feeder;
  localparam int CW = 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        col_valid = 1'b0, col_last = 1'b0;
  logic [31:0] col_data = '0;
  logic        col_ready;
  logic        bf_req_valid, bf_rsp_ready, bcci_rsp_valid;
  logic        bcci_req_ready = 1'b1;
  logic [CW-1:0] p1, p2, p3, p4, p5, p6, p7, p8, p9, p10, p11, p12, p13, p14, p15, p16;
  logic        out_valid, out_band_last;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_row;
`ifdef BCCI_FEEDER_PERF_CNT_EN
  logic [31:0] win_cnt, stall_cnt;
`endif

  // Model core: echo mode answers in the same cycle it accepts a window.
  logic         core_echo = 1'b1;
  logic         rsp_valid_drv = 1'b0;
  logic [127:0] rsp_vec_drv = '0;
  logic [127:0] p_vec, rsp_vec;
  assign p_vec = {p16, p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1};
  assign bcci_rsp_valid = core_echo ? (bf_req_valid && bcci_req_ready) : rsp_valid_drv;
  assign rsp_vec = core_echo ? p_vec : rsp_vec_drv;

  bicubic_window_feeder #(.CHANNEL_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data), .col_last(col_last),
    .bf_req_valid(bf_req_valid), .bcci_req_ready(bcci_req_ready),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .p9(p9), .p10(p10), .p11(p11), .p12(p12), .p13(p13), .p14(p14), .p15(p15), .p16(p16),
    .bcci_rsp_valid(bcci_rsp_valid), .bf_rsp_ready(bf_rsp_ready),
    .bcci_rsp_data1(rsp_vec[7:0]),      .bcci_rsp_data2(rsp_vec[15:8]),
    .bcci_rsp_data3(rsp_vec[23:16]),    .bcci_rsp_data4(rsp_vec[31:24]),
    .bcci_rsp_data5(rsp_vec[39:32]),    .bcci_rsp_data6(rsp_vec[47:40]),
    .bcci_rsp_data7(rsp_vec[55:48]),    .bcci_rsp_data8(rsp_vec[63:56]),
    .bcci_rsp_data9(rsp_vec[71:64]),    .bcci_rsp_data10(rsp_vec[79:72]),
    .bcci_rsp_data11(rsp_vec[87:80]),   .bcci_rsp_data12(rsp_vec[95:88]),
    .bcci_rsp_data13(rsp_vec[103:96]),  .bcci_rsp_data14(rsp_vec[111:104]),
    .bcci_rsp_data15(rsp_vec[119:112]), .bcci_rsp_data16(rsp_vec[127:120]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_band_last(out_band_last)
`ifdef BCCI_FEEDER_PERF_CNT_EN
    , .win_cnt(win_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // out_ready pattern: 0 = always 1, 1 = toggle, 2 = random
  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      out_ready = ~out_ready;
    else if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b1;
  end

  // Monitor: records every handshake with its cycle number.
  int           cyc = 0;
  logic [127:0] obs_req[$];
  int           obs_req_cyc[$];
  logic [34:0]  obs_out[$];
  int           obs_out_cyc[$];
  int           obs_col_cyc[$];
  int           unstable = 0;
  logic         hold_pend = 1'b0;
  logic [127:0] prev_p = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (col_valid && col_ready) obs_col_cyc.push_back(cyc);
      if (bf_req_valid && hold_pend && (p_vec !== prev_p)) unstable++;
      hold_pend = bf_req_valid && !bcci_req_ready;
      prev_p = p_vec;
      if (bf_req_valid && bcci_req_ready) begin
        obs_req.push_back(p_vec);
        obs_req_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        obs_out.push_back({out_band_last, out_row, out_data});
        obs_out_cyc.push_back(cyc);
      end
    end
  end

  // Reference model: windows k = 0..N-4 of a band of N columns.
  logic [31:0]  band_cols[$];
  logic [127:0] exp_req[$];
  logic [34:0]  exp_out[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic model_band();
    int n = band_cols.size();
    logic [31:0]  col, d;
    logic [127:0] v;
    if (n < 4) return;
    for (int k = 0; k <= n - 4; k++) begin
      v = '0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          col = band_cols[k + c];
          v[(4*r + c)*8 +: 8] = col[r*8 +: 8];
        end
      exp_req.push_back(v);
      for (int r = 0; r < 4; r++) begin
        d = '0;
        for (int c = 0; c < 4; c++) begin
          col = band_cols[k + c];
          d[c*8 +: 8] = col[r*8 +: 8];
        end
        exp_out.push_back({(k == n - 4) && (r == 3), 2'(r), d});
      end
    end
  endtask

  task automatic send_col(input logic [31:0] d, input logic last);
    int  w = 0;
    bit  done = 0;
    col_valid = 1'b1; col_data = d; col_last = last;
    while (!done) begin
      @(negedge clk);
      if (col_ready) done = 1;
      else if (w++ > 300) begin
        n_checks++; n_fail++;
        $display("FAIL col_accept timeout: col_ready=0, required 1");
        done = 1;
      end
      @(posedge clk); #1;
    end
    col_valid = 1'b0; col_last = 1'b0;
  endtask

  task automatic send_band();
    for (int i = 0; i < band_cols.size(); i++) send_col(band_cols[i], i == band_cols.size() - 1);
  endtask

  task automatic settle(input int req_t, input int out_t);
    int w = 0;
    while ((obs_req.size() < req_t || obs_out.size() < out_t) && w < 2000) begin
      @(negedge clk); w++;
    end
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pat_col(input int c);
    return {8'(48 + c), 8'(32 + c), 8'(16 + c), 8'(c)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; col_valid = 1'b1; col_last = 1'b1; col_data = '1;
    bcci_req_ready = 1'b1; core_echo = 1'b0; rsp_valid_drv = 1'b1; rsp_vec_drv = '1;
    repeat (3) begin
      @(negedge clk);
      n_checks++; if (bf_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid got %b want 0", bf_req_valid); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      n_checks++; if (bf_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_ready got %b want 0", bf_rsp_ready); end
      n_checks++; if (p_vec !== '0) begin n_fail++; $display("FAIL rst_p got %h want 0", p_vec); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
      @(posedge clk); #1;
    end
    rst = 1'b0; col_valid = 1'b0; col_last = 1'b0; col_data = '0;
    rsp_valid_drv = 1'b0; rsp_vec_drv = '0; core_echo = 1'b1;
    @(negedge clk);
    n_checks++; if (col_ready !== 1'b1) begin n_fail++; $display("FAIL rst_col_ready got %b want 1", col_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_band();
    int rb = obs_req.size(), ob = obs_out.size(), er = exp_req.size(), eo = exp_out.size();
    int tcol;
    logic [127:0] v;
    band_cols.delete();
    for (int c = 0; c < 4; c++) band_cols.push_back(pat_col(c));
    model_band();
    send_band();
    tcol = obs_col_cyc[obs_col_cyc.size() - 1];
    settle(rb + 1, ob + 4);
    n_checks++; if (obs_req.size() - rb !== 1) begin n_fail++; $display("FAIL single_req_count got %0d want 1", obs_req.size() - rb); end
    n_checks++; if (obs_out.size() - ob !== 4) begin n_fail++; $display("FAIL single_out_count got %0d want 4", obs_out.size() - ob); end
    if (obs_req.size() > rb) begin
      v = obs_req[rb];
      n_checks++; if (v[7:0] !== 8'h00 || v[31:24] !== 8'h03 || v[103:96] !== 8'h30 || v[127:120] !== 8'h33) begin
        n_fail++; $display("FAIL single_corners got p1=%h p4=%h p13=%h p16=%h want 00 03 30 33", v[7:0], v[31:24], v[103:96], v[127:120]); end
      n_checks++; if (v !== exp_req[er]) begin n_fail++; $display("FAIL single_window got %h want %h", v, exp_req[er]); end
      n_checks++; if (obs_req_cyc[rb] - tcol !== 1) begin n_fail++; $display("FAIL single_req_latency got %0d want 1", obs_req_cyc[rb] - tcol); end
    end
    for (int i = 0; i < 4; i++) if (ob + i < obs_out.size()) begin
      n_checks++; if (obs_out[ob + i] !== exp_out[eo + i]) begin n_fail++; $display("FAIL single_row%0d got %h want %h", i, obs_out[ob + i], exp_out[eo + i]); end
      n_checks++; if (obs_out_cyc[ob + i] - tcol !== 2 + i) begin n_fail++; $display("FAIL single_row%0d_latency got %0d want %0d", i, obs_out_cyc[ob + i] - tcol, 2 + i); end
    end
  endtask

  task automatic test_wide_band();
    int rb = obs_req.size(), ob = obs_out.size(), er = exp_req.size(), eo = exp_out.size();
    logic [127:0] v;
    band_cols.delete();
    for (int c = 0; c < 6; c++) band_cols.push_back(pat_col(c));
    model_band();
    send_band();
    settle(rb + 3, ob + 12);
    n_checks++; if (obs_req.size() - rb !== 3) begin n_fail++; $display("FAIL wide_req_count got %0d want 3", obs_req.size() - rb); end
    n_checks++; if (obs_out.size() - ob !== 12) begin n_fail++; $display("FAIL wide_out_count got %0d want 12", obs_out.size() - ob); end
    if (obs_req.size() >= rb + 2) begin
      v = obs_req[rb + 1];
      n_checks++; if (v[7:0] !== 8'h01) begin n_fail++; $display("FAIL wide_win2_p1 got %h want 01", v[7:0]); end
      n_checks++; if (obs_req_cyc[rb + 1] - obs_req_cyc[rb] !== 5) begin n_fail++; $display("FAIL wide_req_spacing got %0d want 5", obs_req_cyc[rb + 1] - obs_req_cyc[rb]); end
    end
    for (int i = 0; i < 3; i++) if (rb + i < obs_req.size()) begin
      n_checks++; if (obs_req[rb + i] !== exp_req[er + i]) begin n_fail++; $display("FAIL wide_window%0d got %h want %h", i, obs_req[rb + i], exp_req[er + i]); end
    end
    for (int i = 0; i < 12; i++) if (ob + i < obs_out.size()) begin
      n_checks++; if (obs_out[ob + i] !== exp_out[eo + i]) begin n_fail++; $display("FAIL wide_out%0d got %h want %h", i, obs_out[ob + i], exp_out[eo + i]); end
    end
  endtask

  task automatic test_narrow_band();
    int rb = obs_req.size(), ob = obs_out.size(), er = exp_req.size(), eo = exp_out.size();
    int seen = 0;
    band_cols.delete();
    for (int c = 0; c < 2; c++) band_cols.push_back($urandom);
    model_band();
    send_band();
    repeat (10) begin @(negedge clk); if (bf_req_valid) seen++; @(posedge clk); #1; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL narrow_req_cycles got %0d want 0", seen); end
    band_cols.delete();
    for (int c = 0; c < 4; c++) band_cols.push_back($urandom);
    model_band();
    send_band();
    settle(rb + 1, ob + 4);
    n_checks++; if (obs_req.size() - rb !== 1) begin n_fail++; $display("FAIL narrow_next_req_count got %0d want 1", obs_req.size() - rb); end
    if (obs_req.size() > rb) begin
      n_checks++; if (obs_req[rb] !== exp_req[er]) begin n_fail++; $display("FAIL narrow_next_window got %h want %h", obs_req[rb], exp_req[er]); end
    end
    for (int i = 0; i < 4; i++) if (ob + i < obs_out.size()) begin
      n_checks++; if (obs_out[ob + i] !== exp_out[eo + i]) begin n_fail++; $display("FAIL narrow_next_row%0d got %h want %h", i, obs_out[ob + i], exp_out[eo + i]); end
    end
  endtask

  task automatic test_backpressure();
    int rb = obs_req.size(), ob = obs_out.size(), er = exp_req.size(), eo = exp_out.size();
    int ub = unstable, held = 0;
    bcci_req_ready = 1'b0;
    rdy_mode = 1;
    band_cols.delete();
    for (int c = 0; c < 4; c++) band_cols.push_back($urandom);
    model_band();
    send_band();
    repeat (7) begin @(negedge clk); if (bf_req_valid) held++; @(posedge clk); #1; end
    bcci_req_ready = 1'b1;
    n_checks++; if (held !== 7) begin n_fail++; $display("FAIL bp_req_held got %0d cycles want 7", held); end
    settle(rb + 1, ob + 4);
    rdy_mode = 0;
    n_checks++; if (unstable - ub !== 0) begin n_fail++; $display("FAIL bp_p_stable got %0d changes want 0", unstable - ub); end
    n_checks++; if (obs_req.size() - rb !== 1) begin n_fail++; $display("FAIL bp_req_count got %0d want 1", obs_req.size() - rb); end
    n_checks++; if (obs_out.size() - ob !== 4) begin n_fail++; $display("FAIL bp_out_count got %0d want 4", obs_out.size() - ob); end
    if (obs_req.size() > rb) begin
      n_checks++; if (obs_req[rb] !== exp_req[er]) begin n_fail++; $display("FAIL bp_window got %h want %h", obs_req[rb], exp_req[er]); end
    end
    for (int i = 0; i < 4; i++) if (ob + i < obs_out.size()) begin
      n_checks++; if (obs_out[ob + i] !== exp_out[eo + i]) begin n_fail++; $display("FAIL bp_row%0d got %h want %h", i, obs_out[ob + i], exp_out[eo + i]); end
    end
  endtask

  task automatic test_back_to_back();
    int rb = obs_req.size(), ob = obs_out.size(), er = exp_req.size(), eo = exp_out.size();
    int nreq, nout;
    rdy_mode = 2;
    for (int b = 0; b < 3; b++) begin
      band_cols.delete();
      for (int c = 0; c < int'($urandom_range(4, 7)); c++) band_cols.push_back($urandom);
      model_band();
      send_band();
    end
    nreq = exp_req.size() - er;
    nout = exp_out.size() - eo;
    settle(rb + nreq, ob + nout);
    rdy_mode = 0;
    n_checks++; if (obs_req.size() - rb !== nreq) begin n_fail++; $display("FAIL b2b_req_count got %0d want %0d", obs_req.size() - rb, nreq); end
    n_checks++; if (obs_out.size() - ob !== nout) begin n_fail++; $display("FAIL b2b_out_count got %0d want %0d", obs_out.size() - ob, nout); end
    for (int i = 0; i < nreq; i++) if (rb + i < obs_req.size()) begin
      n_checks++; if (obs_req[rb + i] !== exp_req[er + i]) begin n_fail++; $display("FAIL b2b_window%0d got %h want %h", i, obs_req[rb + i], exp_req[er + i]); end
    end
    for (int i = 0; i < nout; i++) if (ob + i < obs_out.size()) begin
      n_checks++; if (obs_out[ob + i] !== exp_out[eo + i]) begin n_fail++; $display("FAIL b2b_out%0d got %h want %h", i, obs_out[ob + i], exp_out[eo + i]); end
    end
  endtask

  task automatic test_reset_mid();
    core_echo = 1'b0; rsp_valid_drv = 1'b0;
    band_cols.delete();
    for (int c = 0; c < 4; c++) band_cols.push_back($urandom);
    send_band();
    @(negedge clk);
    n_checks++; if (bf_req_valid !== 1'b1) begin n_fail++; $display("FAIL mid_req_valid got %b want 1", bf_req_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (bf_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL mid_wait_rsp_ready got %b want 1", bf_rsp_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_valid_drv = 1'b1; rsp_vec_drv = {$urandom, $urandom, $urandom, $urandom};
    repeat (6) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
      n_checks++; if (bf_rsp_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rsp_ready got %b want 0", bf_rsp_ready); end
      n_checks++; if (bf_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_after got %b want 0", bf_req_valid); end
      n_checks++; if (col_ready !== 1'b1) begin n_fail++; $display("FAIL mid_col_ready got %b want 1", col_ready); end
`ifdef BCCI_FEEDER_PERF_CNT_EN
      n_checks++; if (win_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_win_cnt got %0d want 0", win_cnt); end
`endif
      @(posedge clk); #1;
    end
    rsp_valid_drv = 1'b0; core_echo = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_band();
    test_wide_band();
    test_narrow_band();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule
